// File: rtl/plab5_mcore_dma_block_copy.sv
// plab5_mcore_dma_block_copy: multi-word memory-to-memory copy engine.
// Accepts one command (src, dest, word count, domain), then alternates read
// bursts (up to p_buf_words words) and write bursts through a circular buffer
// on one memory request/response port, and pulses done when finished.
// Ports:
//   clk, reset (async, active-low)
//   cmd_*        command handshake and fields
//   abort        stop after the in-flight memory transaction
//   done*        completion pulse, error flag, words-written count
//   mem_req_*    memory request: val/rdy, control {type,opaque,addr,len}, data, domain
//   mem_resp_*   memory response: val/rdy, control, data, domain
module plab5_mcore_dma_block_copy #(
  parameter  int unsigned p_opaque_nbits = 8,
  parameter  int unsigned p_addr_nbits   = 32,
  parameter  int unsigned p_data_nbits   = 32,
  parameter  int unsigned p_buf_words    = 4,
  parameter  int unsigned p_len_nbits    = 16,
  localparam int unsigned c_mlen_nbits   = $clog2(p_data_nbits / 8),
  localparam int unsigned c_req_cnbits   = 3 + p_opaque_nbits + p_addr_nbits + c_mlen_nbits,
  localparam int unsigned c_resp_cnbits  = 5 + p_opaque_nbits + c_mlen_nbits
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_val,
  output logic                     cmd_rdy,
  input  logic [p_addr_nbits-1:0]  cmd_src_addr,
  input  logic [p_addr_nbits-1:0]  cmd_dest_addr,
  input  logic [p_len_nbits-1:0]   cmd_len,
  input  logic                     cmd_domain,
  input  logic                     abort,
  output logic                     done,
  output logic                     done_err,
  output logic [p_len_nbits-1:0]   done_count,
  output logic                     mem_req_val,
  input  logic                     mem_req_rdy,
  output logic [c_req_cnbits-1:0]  mem_req_control,
  output logic [p_data_nbits-1:0]  mem_req_data,
  output logic                     mem_req_domain,
  input  logic                     mem_resp_val,
  output logic                     mem_resp_rdy,
  input  logic [c_resp_cnbits-1:0] mem_resp_control,
  input  logic [p_data_nbits-1:0]  mem_resp_data,
  input  logic                     mem_resp_domain
);

  localparam int unsigned c_ptr_nbits = $clog2(p_buf_words);
  localparam int unsigned c_idx_nbits = c_ptr_nbits + 1;
  localparam int unsigned c_stride    = p_data_nbits / 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t state, state_next;

  logic [p_addr_nbits-1:0] src_ptr, dest_ptr;
  logic [p_len_nbits-1:0]  rd_left, wr_left, count_q;
  logic                    domain_q, err_q, abort_q;
  logic [c_idx_nbits-1:0]  wr_idx, rd_idx, occ;
  logic [p_data_nbits-1:0] buf_mem [p_buf_words];

  logic accept, push, pop, set_err, active, abort_now, resp_ok;
  logic buf_empty, full_after_push, empty_after_pop;

  // Response control carries nothing this engine needs.
  logic unused_resp_control;
  assign unused_resp_control = ^mem_resp_control;

  // Buffer occupancy; the extra index bit separates full from empty.
  assign occ             = wr_idx - rd_idx;
  assign buf_empty       = (occ == '0);
  assign full_after_push = (occ == c_idx_nbits'(p_buf_words - 1));
  assign empty_after_pop = (occ == c_idx_nbits'(1));

  assign abort_now = abort | abort_q;
  assign resp_ok   = (mem_resp_domain == domain_q);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and control decode
  always_comb begin
    state_next   = state;
    accept       = 1'b0;
    push         = 1'b0;
    pop          = 1'b0;
    set_err      = 1'b0;
    active       = 1'b0;
    cmd_rdy      = 1'b0;
    mem_req_val  = 1'b0;
    mem_resp_rdy = 1'b0;
    done         = 1'b0;
    done_err     = 1'b0;
    case (state)
      IDLE: begin
        cmd_rdy = 1'b1;
        if (cmd_val) begin
          accept     = 1'b1;
          state_next = (cmd_len != '0) ? RD_REQ : DONE;
        end
      end
      RD_REQ: begin
        active      = 1'b1;
        mem_req_val = 1'b1;
        if (mem_req_rdy)    state_next = RD_WAIT;
        else if (abort_now) state_next = DONE;
      end
      RD_WAIT: begin
        active       = 1'b1;
        mem_resp_rdy = 1'b1;
        if (mem_resp_val) begin
          if (!resp_ok) begin
            // Bad word is dropped; good buffered words still get written.
            set_err    = 1'b1;
            state_next = (!buf_empty && !abort_now) ? WR_REQ : DONE;
          end else begin
            push = 1'b1;
            if (abort_now)
              state_next = DONE;
            else if (rd_left != p_len_nbits'(1) && !full_after_push)
              state_next = RD_REQ;
            else
              state_next = WR_REQ;
          end
        end
      end
      WR_REQ: begin
        active      = 1'b1;
        mem_req_val = 1'b1;
        if (mem_req_rdy)    state_next = WR_WAIT;
        else if (abort_now) state_next = DONE;
      end
      WR_WAIT: begin
        active       = 1'b1;
        mem_resp_rdy = 1'b1;
        if (mem_resp_val) begin
          if (!resp_ok) begin
            set_err    = 1'b1;
            state_next = DONE;
          end else begin
            pop = 1'b1;
            if (abort_now || wr_left == p_len_nbits'(1))
              state_next = DONE;
            else if (!empty_after_pop)
              state_next = WR_REQ;
            else if (err_q || rd_left == '0)
              state_next = DONE;
            else
              state_next = RD_REQ;
          end
        end
      end
      DONE: begin
        done       = 1'b1;
        done_err   = err_q;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Command latch, pointers, counters and sticky flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_ptr  <= '0;
      dest_ptr <= '0;
      rd_left  <= '0;
      wr_left  <= '0;
      count_q  <= '0;
      domain_q <= 1'b0;
      err_q    <= 1'b0;
      abort_q  <= 1'b0;
      wr_idx   <= '0;
      rd_idx   <= '0;
    end else begin
      if (accept) begin
        src_ptr  <= cmd_src_addr;
        dest_ptr <= cmd_dest_addr;
        rd_left  <= cmd_len;
        wr_left  <= cmd_len;
        count_q  <= '0;
        domain_q <= cmd_domain;
        err_q    <= 1'b0;
        abort_q  <= 1'b0;
        wr_idx   <= '0;
        rd_idx   <= '0;
      end
      if (active && abort) abort_q <= 1'b1;
      if (set_err || (active && abort)) err_q <= 1'b1;
      if (push) begin
        wr_idx  <= wr_idx + c_idx_nbits'(1);
        src_ptr <= src_ptr + p_addr_nbits'(c_stride);
        rd_left <= rd_left - p_len_nbits'(1);
      end
      if (pop) begin
        rd_idx   <= rd_idx + c_idx_nbits'(1);
        dest_ptr <= dest_ptr + p_addr_nbits'(c_stride);
        wr_left  <= wr_left - p_len_nbits'(1);
        count_q  <= count_q + p_len_nbits'(1);
      end
    end
  end

  // Buffer storage (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (push) buf_mem[wr_idx[c_ptr_nbits-1:0]] <= mem_resp_data;
  end

  // Request payload: held stable by the state and pointers while waiting on rdy.
  assign mem_req_control = {
    (state == WR_REQ) ? 3'h1 : 3'h0,
    p_opaque_nbits'(0),
    (state == WR_REQ) ? dest_ptr : src_ptr,
    c_mlen_nbits'(0)
  };
  assign mem_req_data   = buf_mem[rd_idx[c_ptr_nbits-1:0]];
  assign mem_req_domain = domain_q;
  assign done_count     = count_q;

endmodule

// File: tb/tb_plab5_mcore_dma_block_copy.sv
// Testbench for plab5_mcore_dma_block_copy: random memory responder plus a
// word-level reference model of the burst/copy/abort/error rules.
module tb_plab5_mcore_dma_block_copy;

  localparam int unsigned BUF = 4;

  typedef struct packed {
    logic [44:0] ctl;
    logic [31:0] data;
    logic        dom;
  } req_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_val, cmd_rdy, cmd_domain, abort;
  logic [31:0] cmd_src_addr, cmd_dest_addr;
  logic [15:0] cmd_len;
  logic        done, done_err;
  logic [15:0] done_count;
  logic        mem_req_val, mem_req_rdy, mem_req_domain;
  logic [44:0] mem_req_control;
  logic [31:0] mem_req_data;
  logic        mem_resp_val, mem_resp_rdy, mem_resp_domain;
  logic [14:0] mem_resp_control;
  logic [31:0] mem_resp_data;

  always #5 clk = ~clk;

  plab5_mcore_dma_block_copy dut (
    .clk              (clk),
    .reset            (reset),
    .cmd_val          (cmd_val),
    .cmd_rdy          (cmd_rdy),
    .cmd_src_addr     (cmd_src_addr),
    .cmd_dest_addr    (cmd_dest_addr),
    .cmd_len          (cmd_len),
    .cmd_domain       (cmd_domain),
    .abort            (abort),
    .done             (done),
    .done_err         (done_err),
    .done_count       (done_count),
    .mem_req_val      (mem_req_val),
    .mem_req_rdy      (mem_req_rdy),
    .mem_req_control  (mem_req_control),
    .mem_req_data     (mem_req_data),
    .mem_req_domain   (mem_req_domain),
    .mem_resp_val     (mem_resp_val),
    .mem_resp_rdy     (mem_resp_rdy),
    .mem_resp_control (mem_resp_control),
    .mem_resp_data    (mem_resp_data),
    .mem_resp_domain  (mem_resp_domain)
  );

  int n_checks = 0;
  int n_fail   = 0;

  req_t        req_log [$];
  logic [31:0] ovr [logic [31:0]];
  int          rd_n = 0, wr_n = 0;
  int          cfg_bad_rd = 0, cfg_abort_rd = 0, cfg_abort_wr = 0;
  bit          cfg_abort_req = 0, cfg_stall5 = 0, cfg_hang_wr = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memfn(input logic [31:0] a);
    if (ovr.exists(a)) return ovr[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic req_t mk_req(input bit is_wr, input logic [31:0] a,
                                  input logic [31:0] d, input logic dom);
    req_t r;
    r.ctl  = {is_wr ? 3'h1 : 3'h0, 8'h00, a, 2'b00};
    r.data = is_wr ? d : 32'h0;
    r.dom  = dom;
    return r;
  endfunction

  // Memory responder: random rdy, random latency, one transaction at a time.
  initial begin : responder
    logic [44:0] ctl, stall_ctl;
    logic [31:0] stall_data, a;
    logic        dom;
    bit          stalled, is_wr, rdy;
    int          stall_cnt, lat;
    stalled = 0; stall_cnt = 0;
    mem_req_rdy = 0; mem_resp_val = 0; mem_resp_data = 0;
    mem_resp_domain = 0; mem_resp_control = 0; abort = 0;
    forever begin
      @(negedge clk);
      mem_resp_val = 0;
      abort        = 0;
      if (!(reset && mem_req_val)) begin
        mem_req_rdy = 0; stalled = 0;
        continue;
      end
      ctl   = mem_req_control;
      is_wr = (ctl[44:42] == 3'h1);
      if (stalled) begin
        check("req_stable_ctl", 64'(ctl), 64'(stall_ctl));
        if (is_wr) check("req_stable_data", 64'(mem_req_data), 64'(stall_data));
      end
      if (cfg_abort_req) begin
        mem_req_rdy = 0; abort = 1; stalled = 0;
        continue;
      end
      if (cfg_stall5 && stall_cnt < 5) begin
        rdy = 0; stall_cnt++;
      end else begin
        rdy = ($urandom_range(0, 2) != 0);
      end
      mem_req_rdy = rdy;
      if (!rdy) begin
        stalled = 1; stall_ctl = ctl; stall_data = mem_req_data;
        continue;
      end
      stalled   = 0;
      stall_cnt = 0;
      a   = ctl[33:2];
      dom = mem_req_domain;
      req_log.push_back(mk_req(is_wr, a, mem_req_data, dom));
      @(negedge clk);
      mem_req_rdy = 0;
      if (is_wr) wr_n++; else rd_n++;
      if (!is_wr && rd_n == cfg_abort_rd) begin
        abort = 1;
        @(negedge clk);
        abort = 0;
      end
      lat = $urandom_range(0, 3);
      repeat (lat) @(negedge clk);
      if (is_wr && cfg_hang_wr) begin
        while (cfg_hang_wr) @(negedge clk);
        continue;
      end
      mem_resp_val     = 1;
      mem_resp_domain  = (!is_wr && rd_n == cfg_bad_rd) ? ~dom : dom;
      mem_resp_data    = is_wr ? 32'h0 : memfn(a);
      mem_resp_control = {is_wr ? 3'h1 : 3'h0, 8'h00, 2'b00, 2'b00};
      if (is_wr && wr_n == cfg_abort_wr) abort = 1;
    end
  end

  task automatic send_cmd(input logic [31:0] src, input logic [31:0] dst,
                          input logic [15:0] len, input logic dom);
    int cyc;
    cyc = 0;
    @(negedge clk);
    while (!cmd_rdy && cyc < 200) begin @(negedge clk); cyc++; end
    check("cmd_rdy_idle", 64'(cmd_rdy), 64'd1);
    cmd_val = 1; cmd_src_addr = src; cmd_dest_addr = dst;
    cmd_len = len; cmd_domain = dom;
    @(negedge clk);
    cmd_val = 0;
  endtask

  // Reference copy: chunked read bursts then write bursts, with the early
  // stop rules for a bad read domain or an abort on a read or write.
  task automatic run_copy(input string name, input logic [31:0] src, input logic [31:0] dst,
                          input int len, input logic dom, input int bad_k,
                          input int abrd_k, input int abwr_k, input bit abreq,
                          output int cyc);
    req_t exp_q [$];
    int   base, i_rd, i_wr, cs, n, exp_cnt, n_got;
    bit   bad, ab;
    base = req_log.size();
    i_rd = 0; i_wr = 0; bad = 0; ab = 0;
    if (!abreq) begin
      while (!(ab || bad) && i_wr < len) begin
        cs = i_rd;
        n  = (len - i_rd < BUF) ? len - i_rd : BUF;
        for (int j = 0; j < n; j++) begin
          exp_q.push_back(mk_req(0, src + 32'(4 * i_rd), 32'h0, dom));
          if (i_rd + 1 == bad_k) begin bad = 1; break; end
          i_rd++;
          if (i_rd == abrd_k) begin ab = 1; break; end
        end
        if (ab) break;
        for (int w = cs; w < i_rd; w++) begin
          exp_q.push_back(mk_req(1, dst + 32'(4 * w), memfn(src + 32'(4 * w)), dom));
          i_wr++;
          if (i_wr == abwr_k) begin ab = 1; break; end
        end
      end
    end
    exp_cnt = abreq ? 0 : i_wr;

    cfg_bad_rd    = (bad_k  != 0) ? rd_n + bad_k  : 0;
    cfg_abort_rd  = (abrd_k != 0) ? rd_n + abrd_k : 0;
    cfg_abort_wr  = (abwr_k != 0) ? wr_n + abwr_k : 0;
    cfg_abort_req = abreq;

    send_cmd(src, dst, 16'(len), dom);
    cyc = 0;
    while (!done && cyc < 4000) begin @(negedge clk); cyc++; end
    check({name, ":done_seen"}, 64'(done), 64'd1);
    check({name, ":done_err"}, 64'(done_err), 64'(bad || ab || abreq));
    check({name, ":done_count"}, 64'(done_count), 64'(exp_cnt));
    @(negedge clk);
    check({name, ":done_one_cycle"}, 64'(done), 64'd0);
    check({name, ":count_held"}, 64'(done_count), 64'(exp_cnt));

    n_got = req_log.size() - base;
    check({name, ":req_count"}, 64'(n_got), 64'(exp_q.size()));
    for (int i = 0; i < n_got && i < exp_q.size(); i++) begin
      check($sformatf("%s:req%0d_ctl", name, i), 64'(req_log[base+i].ctl), 64'(exp_q[i].ctl));
      check($sformatf("%s:req%0d_data", name, i), 64'(req_log[base+i].data), 64'(exp_q[i].data));
      check($sformatf("%s:req%0d_dom", name, i), 64'(req_log[base+i].dom), 64'(exp_q[i].dom));
    end
    cfg_bad_rd = 0; cfg_abort_rd = 0; cfg_abort_wr = 0; cfg_abort_req = 0;
  endtask

  initial begin : main
    int cyc, w0, len, mode, k;
    logic [31:0] src, dst;
    reset = 0; cmd_val = 0; cmd_src_addr = 0; cmd_dest_addr = 0;
    cmd_len = 0; cmd_domain = 0;
    repeat (3) @(negedge clk);
    check("rst:cmd_rdy", 64'(cmd_rdy), 64'd1);
    check("rst:mem_req_val", 64'(mem_req_val), 64'd0);
    check("rst:mem_resp_rdy", 64'(mem_resp_rdy), 64'd0);
    check("rst:done", 64'(done), 64'd0);
    check("rst:done_err", 64'(done_err), 64'd0);
    check("rst:done_count", 64'(done_count), 64'd0);
    check("rst:mem_req_domain", 64'(mem_req_domain), 64'd0);
    reset = 1;

    ovr[32'h100] = 32'hA; ovr[32'h104] = 32'hB; ovr[32'h108] = 32'hC;
    run_copy("len3", 32'h100, 32'h200, 3, 1'b0, 0, 0, 0, 0, cyc);
    run_copy("len6", 32'h1000, 32'h2000, 6, 1'b1, 0, 0, 0, 0, cyc);
    run_copy("len0", 32'h500, 32'h600, 0, 1'b0, 0, 0, 0, 0, cyc);
    check("len0:done_latency", 64'(cyc), 64'd0);
    cfg_stall5 = 1;
    run_copy("stall", 32'h700, 32'h800, 2, 1'b1, 0, 0, 0, 0, cyc);
    cfg_stall5 = 0;
    run_copy("dom_err", 32'h900, 32'hA00, 4, 1'b1, 2, 0, 0, 0, cyc);
    run_copy("abort_rd", 32'hB00, 32'hC00, 4, 1'b0, 0, 2, 0, 0, cyc);
    run_copy("abort_wr", 32'hD00, 32'hE00, 6, 1'b1, 0, 0, 1, 0, cyc);
    run_copy("abort_req", 32'hF00, 32'h1F00, 5, 1'b0, 0, 0, 0, 1, cyc);
    run_copy("wrap", 32'hFFFF_FFF8, 32'hFFFF_FFFC, 5, 1'b0, 0, 0, 0, 0, cyc);

    // Reset while a write response is outstanding.
    cfg_hang_wr = 1;
    send_cmd(32'h3000, 32'h4000, 16'd3, 1'b1);
    w0 = wr_n; cyc = 0;
    while (wr_n == w0 && cyc < 500) begin @(negedge clk); cyc++; end
    check("rst_mid:write_issued", 64'(wr_n != w0), 64'd1);
    #1;
    check("rst_mid:in_wr_wait", 64'(mem_resp_rdy), 64'd1);
    reset = 0;
    #1;
    check("rst_mid:cmd_rdy", 64'(cmd_rdy), 64'd1);
    check("rst_mid:mem_req_val", 64'(mem_req_val), 64'd0);
    check("rst_mid:mem_resp_rdy", 64'(mem_resp_rdy), 64'd0);
    check("rst_mid:done", 64'(done), 64'd0);
    check("rst_mid:done_count", 64'(done_count), 64'd0);
    @(negedge clk);
    cfg_hang_wr = 0;
    check("rst_mid:no_done", 64'(done), 64'd0);
    @(negedge clk);
    reset = 1;
    run_copy("after_rst", 32'h5000, 32'h6000, 5, 1'b1, 0, 0, 0, 0, cyc);

    for (int it = 0; it < 20; it++) begin
      len  = $urandom_range(1, 20);
      mode = $urandom_range(0, 5);
      k    = $urandom_range(1, len);
      src  = $urandom & 32'hFFFF_FFFC;
      dst  = $urandom & 32'hFFFF_FFFC;
      run_copy($sformatf("rnd%0d", it), src, dst, len, 1'($urandom),
               (mode == 3) ? k : 0, (mode == 4) ? k : 0, (mode == 5) ? k : 0, 0, cyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
